uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding a UART transmitter
// Grants one requester at a time, hands its byte over with Dvalid and tracks the transmitter's busy flag.
module uart_tx_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 255,
  localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic               tx_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               Dvalid,
  output logic [7:0]         data,
  input  logic               txbusy,
  output logic [OW-1:0]      owner,
  output logic               owner_valid,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [N_REQ-1:0] ack_q;
  logic             dvalid_q;
  logic [7:0]       data_q;
  logic [OW-1:0]    owner_q;
  logic             owner_valid_q;
  logic             timeout_err_q;
  logic [CW-1:0]    cnt_q;
  logic [OW-1:0]    last_grant_q;

  logic             gnt_found;
  logic [OW-1:0]    gnt_idx;
  int               cand;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = (int'(last_grant_q) + off) % N_REQ;
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = OW'(cand);
      end
    end
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ack_q         <= '0;
      dvalid_q      <= 1'b0;
      data_q        <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      last_grant_q  <= OW'(N_REQ - 1);
    end else begin
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!txbusy && gnt_found) begin
            ack_q         <= N_REQ'(1) << gnt_idx;
            data_q        <= req_data[8*int'(gnt_idx) +: 8];
            owner_q       <= gnt_idx;
            last_grant_q  <= gnt_idx;
            dvalid_q      <= 1'b1;
            owner_valid_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (txbusy) begin
            dvalid_q <= 1'b0;
            state_q  <= WAIT_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Byte is dropped; last_grant keeps pointing at this requester.
            dvalid_q      <= 1'b0;
            owner_valid_q <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!txbusy) begin
            owner_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign Dvalid      = dvalid_q;
  assign data        = data_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
